reg_writeback_queue: RTL and testbench

//  Write-side initiator for the 4-entry register file: buffers result writes (reg index + data)

---
 rtl/reg_writeback_queue_pkg.sv | 27 ++
 rtl/reg_writeback_queue_if.sv | 38 +++
 rtl/reg_writeback_queue_youngest_match.sv | 31 +++
 rtl/reg_writeback_queue.sv | 95 +++++++++
 tb/tb_reg_writeback_queue.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Shared sizes and entry type for the register write-back queue.
// Widths track the register file (WORD_SIZE, NUM_REGS) so both sides agree.
package reg_writeback_queue_pkg;

  localparam int WORD_SIZE = 16;
  localparam int NUM_REGS  = 4;
  localparam int REG_AW    = 2;
  localparam int WBQ_DEPTH = 4;
  localparam int PTR_W     = $clog2(WBQ_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef logic [REG_AW-1:0]    reg_idx_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  typedef struct packed {
    reg_idx_t reg_idx;
    word_t    data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t r);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Producer, register-file write port and bypass signals of the write-back queue.
// The queue itself uses the slave view; the producer/decode side uses master.
interface reg_writeback_queue_if;
  import reg_writeback_queue_pkg::*;

  logic                in_valid;
  logic                in_ready;
  reg_idx_t            in_reg;
  word_t               in_data;

  logic                wr_hold;
  logic                ctrlRegWrite;
  reg_idx_t            writeReg;
  word_t               writeData;

  reg_idx_t            lookup_reg1;
  reg_idx_t            lookup_reg2;
  logic                hit1;
  logic                hit2;
  word_t               bypass_data1;
  word_t               bypass_data2;

  logic [NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]    count;

  modport master (
    output in_valid, in_reg, in_data, wr_hold, lookup_reg1, lookup_reg2,
    input  in_ready, ctrlRegWrite, writeReg, writeData,
           hit1, hit2, bypass_data1, bypass_data2, pending, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, wr_hold, lookup_reg1, lookup_reg2,
    output in_ready, ctrlRegWrite, writeReg, writeData,
           hit1, hit2, bypass_data1, bypass_data2, pending, count
  );

endinterface

// File: rtl/reg_writeback_queue_youngest_match.sv
// Bypass lookup: finds the youngest queued entry targeting a register.
// Valid entries are contiguous from head, so walking forward from head and
// letting later matches overwrite earlier ones gives the same result as a
// priority scan from tail-1 back to head.
module wbq_youngest_match
  import reg_writeback_queue_pkg::*;
(
  input  logic [WBQ_DEPTH-1:0]  valid,
  input  wb_entry_t [WBQ_DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      head,
  input  reg_idx_t              query,
  output logic                  hit,
  output word_t                 data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < WBQ_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (entries[idx].reg_idx == query)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order write-back queue in front of the register file: buffers results,
// drains one per cycle, and exposes pending/bypass views of queued writes.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  reg_writeback_queue_if.slave bus
);

  wb_entry_t [WBQ_DEPTH-1:0] entries;
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic [CNT_W-1:0]          occ;
  logic [WBQ_DEPTH-1:0]      valid;
  logic [PTR_W-1:0]          offset;
  logic [NUM_REGS-1:0]       pend;
  logic                      empty;
  logic                      full;
  logic                      do_pop;
  logic                      do_push;

  assign empty   = (occ == '0);
  assign full    = (occ == CNT_W'(WBQ_DEPTH));
  assign do_pop  = !empty && !bus.wr_hold && !reset;
  assign do_push = bus.in_valid && bus.in_ready;

  // A pop frees a slot on the same edge, so a full queue still accepts while draining.
  assign bus.ctrlRegWrite = do_pop;
  assign bus.in_ready     = !reset && (!full || do_pop);
  assign bus.writeReg     = empty ? '0 : entries[head].reg_idx;
  assign bus.writeData    = empty ? '0 : entries[head].data;
  assign bus.count        = occ;
  assign bus.pending      = pend;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < WBQ_DEPTH; i++) begin
      offset   = PTR_W'(i) - head;
      valid[i] = ({1'b0, offset} < occ);
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < WBQ_DEPTH; i++) begin
      if (valid[i]) begin
        pend = pend | reg_onehot(entries[i].reg_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      entries <= '0;
    end else begin
      if (do_push) begin
        entries[tail] <= '{reg_idx: bus.in_reg, data: bus.in_data};
        tail          <= tail + PTR_W'(1);
      end
      if (do_pop) begin
        head <= head + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  wbq_youngest_match u_match1 (
    .valid   (valid),
    .entries (entries),
    .head    (head),
    .query   (bus.lookup_reg1),
    .hit     (bus.hit1),
    .data    (bus.bypass_data1)
  );

  wbq_youngest_match u_match2 (
    .valid   (valid),
    .entries (entries),
    .head    (head),
    .query   (bus.lookup_reg2),
    .hit     (bus.hit2),
    .data    (bus.bypass_data2)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus a random run, all
// checked against a queue-based reference model and a modelled register file.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;

  logic clk;
  logic reset;
  logic rf_clear;
  int   total;
  int   bad;

  wb_entry_t mq[$];
  word_t     rf_model [NUM_REGS];
  word_t     rf_seen  [NUM_REGS];

  reg_writeback_queue_if bus();

  reg_writeback_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed only by the DUT write port.
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int r = 0; r < NUM_REGS; r++) rf_seen[r] <= '0;
    end else if (bus.ctrlRegWrite) begin
      rf_seen[bus.writeReg] <= bus.writeData;
    end
  end

  function automatic logic exp_write();
    return !reset && (mq.size() > 0) && !bus.wr_hold;
  endfunction

  function automatic logic exp_ready();
    return !reset && ((mq.size() < WBQ_DEPTH) || exp_write());
  endfunction

  function automatic logic [NUM_REGS-1:0] exp_pending();
    logic [NUM_REGS-1:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i].reg_idx] = 1'b1;
    return p;
  endfunction

  // Youngest queued write to r wins: the last match in arrival order.
  task automatic model_lookup(input reg_idx_t r, output logic h, output word_t d);
    h = 1'b0;
    d = '0;
    foreach (mq[i]) begin
      if (mq[i].reg_idx == r) begin
        h = 1'b1;
        d = mq[i].data;
      end
    end
  endtask

  task automatic advance();
    logic w;
    logic rdy;
    w   = exp_write();
    rdy = exp_ready();
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
      if (w) begin
        rf_model[mq[0].reg_idx] = mq[0].data;
        mq.delete(0);
      end
      if (bus.in_valid && rdy) mq.push_back('{reg_idx: bus.in_reg, data: bus.in_data});
    end
    #2;
  endtask

  task automatic test_reset();
    bus.wr_hold  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_reg  = reg_idx_t'(i + 1);
      bus.in_data = word_t'(16'h0100 + i);
      #1;
      advance();
    end
    bus.in_valid    = 1'b0;
    bus.lookup_reg1 = reg_idx_t'(1);
    #1;
    total++; if (bus.count !== CNT_W'(3)) begin bad++; $display("[TB] FAIL reset_prefill_count: got %0d expected 3", bus.count); end
    bus.wr_hold = 1'b0;
    reset       = 1'b1;
    #1;
    total++; if (bus.ctrlRegWrite !== 1'b0) begin bad++; $display("[TB] FAIL reset_no_write: got %b expected 0", bus.ctrlRegWrite); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_low: got %b expected 0", bus.in_ready); end
    advance();
    reset = 1'b0;
    #1;
    total++; if (bus.count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("[TB] FAIL reset_pending: got %b expected 0000", bus.pending); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.in_ready); end
    total++; if (bus.hit1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_hit1: got %b expected 0", bus.hit1); end
    total++; if ({bus.ctrlRegWrite, bus.writeReg, bus.writeData} !== '0) begin bad++; $display("[TB] FAIL reset_write_port: got %b/%0d/%h expected 0/0/0", bus.ctrlRegWrite, bus.writeReg, bus.writeData); end
    total++; if (bus.bypass_data1 !== '0) begin bad++; $display("[TB] FAIL reset_bypass1: got %h expected 0", bus.bypass_data1); end
    for (int r = 0; r < NUM_REGS; r++) begin
      total++; if (rf_seen[r] !== rf_model[r]) begin bad++; $display("[TB] FAIL reset_rf%0d: got %h expected %h", r, rf_seen[r], rf_model[r]); end
    end
  endtask

  task automatic test_single_write();
    bus.wr_hold  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_reg   = reg_idx_t'(2);
    bus.in_data  = 16'hBEEF;
    #1;
    total++; if (bus.ctrlRegWrite !== 1'b0) begin bad++; $display("[TB] FAIL single_no_writethrough: got %b expected 0", bus.ctrlRegWrite); end
    advance();
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.ctrlRegWrite !== 1'b1) begin bad++; $display("[TB] FAIL single_strobe: got %b expected 1", bus.ctrlRegWrite); end
    total++; if (bus.writeReg !== reg_idx_t'(2)) begin bad++; $display("[TB] FAIL single_reg: got %0d expected 2", bus.writeReg); end
    total++; if (bus.writeData !== 16'hBEEF) begin bad++; $display("[TB] FAIL single_data: got %h expected beef", bus.writeData); end
    advance();
    #1;
    total++; if (bus.count !== '0) begin bad++; $display("[TB] FAIL single_count: got %0d expected 0", bus.count); end
    total++; if (rf_seen[2] !== 16'hBEEF) begin bad++; $display("[TB] FAIL single_rf2: got %h expected beef", rf_seen[2]); end
  endtask

  task automatic test_fill_hold();
    bus.wr_hold  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_reg  = reg_idx_t'(i);
      bus.in_data = word_t'(i + 1);
      #1;
      advance();
    end
    bus.in_reg  = reg_idx_t'(0);
    bus.in_data = 16'h5555;
    #1;
    total++; if (bus.count !== CNT_W'(4)) begin bad++; $display("[TB] FAIL fill_count: got %0d expected 4", bus.count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_ready: got %b expected 0", bus.in_ready); end
    advance();
    bus.in_valid = 1'b0;
    bus.wr_hold  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (bus.ctrlRegWrite !== 1'b1 || bus.writeReg !== reg_idx_t'(i) || bus.writeData !== word_t'(i + 1)) begin
        bad++; $display("[TB] FAIL fill_drain%0d: got %b/%0d/%h expected 1/%0d/%h", i, bus.ctrlRegWrite, bus.writeReg, bus.writeData, i, i + 1);
      end
      advance();
    end
    #1;
    total++; if (bus.count !== '0) begin bad++; $display("[TB] FAIL fill_after_count: got %0d expected 0 (5th push leaked)", bus.count); end
    total++; if (rf_seen[0] !== 16'h0001) begin bad++; $display("[TB] FAIL fill_rf0: got %h expected 0001", rf_seen[0]); end
  endtask

  task automatic test_youngest_bypass();
    bus.wr_hold  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_reg   = reg_idx_t'(1);
    bus.in_data  = 16'hAAAA;
    #1;
    advance();
    bus.in_data = 16'hBBBB;
    #1;
    advance();
    bus.in_valid    = 1'b0;
    bus.lookup_reg1 = reg_idx_t'(1);
    #1;
    total++; if (bus.hit1 !== 1'b1 || bus.bypass_data1 !== 16'hBBBB) begin bad++; $display("[TB] FAIL byp_youngest: got %b/%h expected 1/bbbb", bus.hit1, bus.bypass_data1); end
    total++; if (bus.pending !== 4'b0010) begin bad++; $display("[TB] FAIL byp_pending: got %b expected 0010", bus.pending); end
    bus.wr_hold = 1'b0;
    #1;
    total++; if (bus.writeData !== 16'hAAAA) begin bad++; $display("[TB] FAIL byp_first_out: got %h expected aaaa", bus.writeData); end
    advance();
    #1;
    total++; if (bus.pending !== 4'b0010) begin bad++; $display("[TB] FAIL byp_pending_mid: got %b expected 0010", bus.pending); end
    total++; if (bus.hit1 !== 1'b1 || bus.bypass_data1 !== 16'hBBBB) begin bad++; $display("[TB] FAIL byp_mid: got %b/%h expected 1/bbbb", bus.hit1, bus.bypass_data1); end
    advance();
    #1;
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("[TB] FAIL byp_pending_clr: got %b expected 0000", bus.pending); end
    total++; if (bus.hit1 !== 1'b0 || bus.bypass_data1 !== '0) begin bad++; $display("[TB] FAIL byp_clr: got %b/%h expected 0/0", bus.hit1, bus.bypass_data1); end
    total++; if (rf_seen[1] !== 16'hBBBB) begin bad++; $display("[TB] FAIL byp_rf1: got %h expected bbbb", rf_seen[1]); end
  endtask

  task automatic test_full_push_pop();
    bus.wr_hold  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_reg  = reg_idx_t'($urandom_range(0, 3));
      bus.in_data = word_t'($urandom);
      #1;
      advance();
    end
    bus.wr_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_reg  = reg_idx_t'($urandom_range(0, 3));
      bus.in_data = word_t'($urandom);
      #1;
      total++; if (bus.in_ready !== 1'b1 || bus.count !== CNT_W'(4)) begin bad++; $display("[TB] FAIL stream_full%0d: got ready=%b count=%0d expected 1/4", i, bus.in_ready, bus.count); end
      total++; if (bus.ctrlRegWrite !== 1'b1 || bus.writeReg !== mq[0].reg_idx || bus.writeData !== mq[0].data) begin
        bad++; $display("[TB] FAIL stream_order%0d: got %b/%0d/%h expected 1/%0d/%h", i, bus.ctrlRegWrite, bus.writeReg, bus.writeData, mq[0].reg_idx, mq[0].data);
      end
      advance();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8 && mq.size() > 0; i++) begin
      #1;
      total++; if (bus.ctrlRegWrite !== 1'b1 || bus.writeReg !== mq[0].reg_idx || bus.writeData !== mq[0].data) begin
        bad++; $display("[TB] FAIL stream_drain%0d: got %b/%0d/%h expected 1/%0d/%h", i, bus.ctrlRegWrite, bus.writeReg, bus.writeData, mq[0].reg_idx, mq[0].data);
      end
      advance();
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      total++; if (rf_seen[r] !== rf_model[r]) begin bad++; $display("[TB] FAIL stream_rf%0d: got %h expected %h", r, rf_seen[r], rf_model[r]); end
    end
  endtask

  task automatic test_same_cycle();
    bus.wr_hold     = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_reg      = reg_idx_t'(3);
    bus.in_data     = 16'h1234;
    bus.lookup_reg2 = reg_idx_t'(3);
    #1;
    total++; if (bus.hit2 !== 1'b0 || bus.pending !== 4'b0000) begin bad++; $display("[TB] FAIL same_cycle_hidden: got hit2=%b pending=%b expected 0/0000", bus.hit2, bus.pending); end
    advance();
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.hit2 !== 1'b1 || bus.bypass_data2 !== 16'h1234) begin bad++; $display("[TB] FAIL same_cycle_next: got %b/%h expected 1/1234", bus.hit2, bus.bypass_data2); end
    total++; if (bus.pending !== 4'b1000) begin bad++; $display("[TB] FAIL same_cycle_pending: got %b expected 1000", bus.pending); end
    bus.wr_hold = 1'b0;
    advance();
    #1;
    total++; if (bus.count !== '0 || rf_seen[3] !== 16'h1234) begin bad++; $display("[TB] FAIL same_cycle_commit: got count=%0d rf3=%h expected 0/1234", bus.count, rf_seen[3]); end
  endtask

  task automatic test_random();
    logic     h1;
    logic     h2;
    word_t    d1;
    word_t    d2;
    reg_idx_t er;
    word_t    ed;
    for (int c = 0; c < 300; c++) begin
      reset           = ($urandom_range(0, 39) == 0);
      bus.in_valid    = 1'($urandom_range(0, 1));
      bus.wr_hold     = ($urandom_range(0, 3) == 0);
      bus.in_reg      = reg_idx_t'($urandom_range(0, 3));
      bus.in_data     = word_t'($urandom);
      bus.lookup_reg1 = reg_idx_t'($urandom_range(0, 3));
      bus.lookup_reg2 = reg_idx_t'($urandom_range(0, 3));
      #1;
      model_lookup(bus.lookup_reg1, h1, d1);
      model_lookup(bus.lookup_reg2, h2, d2);
      er = (mq.size() > 0) ? mq[0].reg_idx : '0;
      ed = (mq.size() > 0) ? mq[0].data : '0;
      total++; if (bus.ctrlRegWrite !== exp_write() || bus.in_ready !== exp_ready()) begin bad++; $display("[TB] FAIL rnd_handshake%0d: got wr=%b rdy=%b expected %b/%b", c, bus.ctrlRegWrite, bus.in_ready, exp_write(), exp_ready()); end
      total++; if (bus.writeReg !== er || bus.writeData !== ed) begin bad++; $display("[TB] FAIL rnd_head%0d: got %0d/%h expected %0d/%h", c, bus.writeReg, bus.writeData, er, ed); end
      total++; if (bus.count !== CNT_W'(mq.size()) || bus.pending !== exp_pending()) begin bad++; $display("[TB] FAIL rnd_state%0d: got count=%0d pending=%b expected %0d/%b", c, bus.count, bus.pending, mq.size(), exp_pending()); end
      total++; if (bus.hit1 !== h1 || bus.bypass_data1 !== d1) begin bad++; $display("[TB] FAIL rnd_byp1_%0d: got %b/%h expected %b/%h", c, bus.hit1, bus.bypass_data1, h1, d1); end
      total++; if (bus.hit2 !== h2 || bus.bypass_data2 !== d2) begin bad++; $display("[TB] FAIL rnd_byp2_%0d: got %b/%h expected %b/%h", c, bus.hit2, bus.bypass_data2, h2, d2); end
      advance();
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.wr_hold  = 1'b0;
    for (int i = 0; i < 6; i++) advance();
    for (int r = 0; r < NUM_REGS; r++) begin
      total++; if (rf_seen[r] !== rf_model[r]) begin bad++; $display("[TB] FAIL rnd_rf%0d: got %h expected %h", r, rf_seen[r], rf_model[r]); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    total           = 0;
    bad             = 0;
    reset           = 1'b1;
    rf_clear        = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_reg      = '0;
    bus.in_data     = '0;
    bus.wr_hold     = 1'b0;
    bus.lookup_reg1 = '0;
    bus.lookup_reg2 = '0;
    for (int r = 0; r < NUM_REGS; r++) rf_model[r] = '0;
    advance();
    advance();
    reset    = 1'b0;
    rf_clear = 1'b0;
    test_reset();
    test_single_write();
    test_fill_hold();
    test_youngest_bypass();
    test_full_push_pop();
    test_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
